// File: rtl/alu_long_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : alu_long_sequencer
// Description : Sequences a BITS-wide combinational Alu once (word) or twice
//               (long) and merges the passes into a 68k-style XNZVC flag set.
// Revision    : 1.0  initial release
// ============================================================================
module alu_long_sequencer #(
    parameter int BITS = 16
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic                START,
    input  logic                SIZE,
    input  logic                USE_X,
    input  logic                XIN,
    input  logic                ZIN,
    input  logic [2*BITS-1:0]   A,
    input  logic [2*BITS-1:0]   B,
    output logic [BITS-1:0]     ALU_A,
    output logic [BITS-1:0]     ALU_B,
    output logic                ALU_X,
    input  logic [BITS-1:0]     ALU_O,
    input  logic                ALU_C,
    input  logic                ALU_Z,
    input  logic                ALU_V,
    input  logic                ALU_N,
    output logic [2*BITS-1:0]   RESULT,
    output logic                XF,
    output logic                NF,
    output logic                ZF,
    output logic                VF,
    output logic                CF,
    output logic                BUSY,
    output logic                DONE
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOW  = 2'd1,
        S_HIGH = 2'd2,
        S_FIN  = 2'd3
    } state_t;

    state_t              state_q;
    logic                size_q;
    logic                use_x_q;
    logic                zin_q;
    logic [BITS-1:0]     a_hi_q;
    logic [BITS-1:0]     b_hi_q;
    logic [BITS-1:0]     lo_q;
    logic                z_lo_q;
    logic [BITS-1:0]     alu_a_q;
    logic [BITS-1:0]     alu_b_q;
    logic                alu_x_q;
    logic [2*BITS-1:0]   result_q;
    logic                xf_q, nf_q, zf_q, vf_q, cf_q;
    logic                busy_q;
    logic                done_q;

    // Sticky Z for ADDX: a clear incoming Z forces the result Z clear.
    logic                z_keep_d;
    logic                z_word_d;
    logic                z_long_d;

    assign z_keep_d = ~use_x_q | zin_q;
    assign z_word_d = ALU_Z & z_keep_d;
    assign z_long_d = z_lo_q & ALU_Z & z_keep_d;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q  <= S_IDLE;
            size_q   <= 1'b0;
            use_x_q  <= 1'b0;
            zin_q    <= 1'b0;
            a_hi_q   <= '0;
            b_hi_q   <= '0;
            lo_q     <= '0;
            z_lo_q   <= 1'b0;
            alu_a_q  <= '0;
            alu_b_q  <= '0;
            alu_x_q  <= 1'b0;
            result_q <= '0;
            xf_q     <= 1'b0;
            nf_q     <= 1'b0;
            zf_q     <= 1'b0;
            vf_q     <= 1'b0;
            cf_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_FIN: begin
                    done_q  <= 1'b0;
                    alu_a_q <= '0;
                    alu_b_q <= '0;
                    alu_x_q <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                    if (START) begin
                        size_q  <= SIZE;
                        use_x_q <= USE_X;
                        zin_q   <= ZIN;
                        a_hi_q  <= A[2*BITS-1:BITS];
                        b_hi_q  <= B[2*BITS-1:BITS];
                        // Alu inputs are registered, so load the low pass now.
                        alu_a_q <= A[BITS-1:0];
                        alu_b_q <= B[BITS-1:0];
                        alu_x_q <= USE_X & XIN;
                        busy_q  <= 1'b1;
                        state_q <= S_LOW;
                    end
                end
                S_LOW: begin
                    lo_q   <= ALU_O;
                    z_lo_q <= ALU_Z;
                    if (size_q) begin
                        alu_a_q <= a_hi_q;
                        alu_b_q <= b_hi_q;
                        alu_x_q <= ALU_C;
                        state_q <= S_HIGH;
                    end else begin
                        result_q <= {a_hi_q, ALU_O};
                        xf_q     <= ALU_C;
                        cf_q     <= ALU_C;
                        vf_q     <= ALU_V;
                        nf_q     <= ALU_N;
                        zf_q     <= z_word_d;
                        alu_a_q  <= '0;
                        alu_b_q  <= '0;
                        alu_x_q  <= 1'b0;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        state_q  <= S_FIN;
                    end
                end
                S_HIGH: begin
                    result_q <= {ALU_O, lo_q};
                    xf_q     <= ALU_C;
                    cf_q     <= ALU_C;
                    vf_q     <= ALU_V;
                    nf_q     <= ALU_N;
                    zf_q     <= z_long_d;
                    alu_a_q  <= '0;
                    alu_b_q  <= '0;
                    alu_x_q  <= 1'b0;
                    busy_q   <= 1'b0;
                    done_q   <= 1'b1;
                    state_q  <= S_FIN;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign ALU_A  = alu_a_q;
    assign ALU_B  = alu_b_q;
    assign ALU_X  = alu_x_q;
    assign RESULT = result_q;
    assign XF     = xf_q;
    assign NF     = nf_q;
    assign ZF     = zf_q;
    assign VF     = vf_q;
    assign CF     = cf_q;
    assign BUSY   = busy_q;
    assign DONE   = done_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_long_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_long_sequencer
// Description : Self-checking bench for alu_long_sequencer with an attached
//               16-bit Alu and a whole-operation arithmetic reference model.
// Revision    : 1.0  initial release
// ============================================================================
module tb_alu_long_sequencer;

    logic        CLK;
    logic        RESET;
    logic        START;
    logic        SIZE;
    logic        USE_X;
    logic        XIN;
    logic        ZIN;
    logic [31:0] A;
    logic [31:0] B;
    logic [15:0] ALU_A;
    logic [15:0] ALU_B;
    logic        ALU_X;
    logic [15:0] ALU_O;
    logic        ALU_C;
    logic        ALU_Z;
    logic        ALU_V;
    logic        ALU_N;
    logic [31:0] RESULT;
    logic        XF, NF, ZF, VF, CF;
    logic        BUSY;
    logic        DONE;

    int n_assert;
    int n_fail;
    logic [31:0] prev_res;
    logic [4:0]  prev_f;

    alu_long_sequencer #(.BITS(16)) dut (
        .CLK    (CLK),
        .RESET  (RESET),
        .START  (START),
        .SIZE   (SIZE),
        .USE_X  (USE_X),
        .XIN    (XIN),
        .ZIN    (ZIN),
        .A      (A),
        .B      (B),
        .ALU_A  (ALU_A),
        .ALU_B  (ALU_B),
        .ALU_X  (ALU_X),
        .ALU_O  (ALU_O),
        .ALU_C  (ALU_C),
        .ALU_Z  (ALU_Z),
        .ALU_V  (ALU_V),
        .ALU_N  (ALU_N),
        .RESULT (RESULT),
        .XF     (XF),
        .NF     (NF),
        .ZF     (ZF),
        .VF     (VF),
        .CF     (CF),
        .BUSY   (BUSY),
        .DONE   (DONE)
    );

    // Combinational 16-bit Alu the sequencer drives.
    logic [16:0] alu_sum;
    assign alu_sum = {1'b0, ALU_A} + {1'b0, ALU_B} + {16'd0, ALU_X};
    assign ALU_O   = alu_sum[15:0];
    assign ALU_C   = alu_sum[16];
    assign ALU_Z   = (alu_sum[15:0] == 16'd0);
    assign ALU_N   = alu_sum[15];
    assign ALU_V   = (ALU_A[15] == ALU_B[15]) && (alu_sum[15] != ALU_A[15]);

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  f;     // {X,N,Z,V,C}
        logic        clo;   // carry out of the low half
    } exp_t;

    function automatic exp_t model(input bit size, input bit usex, input bit xin,
                                   input bit zin, input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        logic [16:0] lo;
        logic [32:0] full;
        logic        c, v, n, zb;
        lo    = {1'b0, a[15:0]} + {1'b0, b[15:0]} + {16'd0, usex & xin};
        full  = {1'b0, a} + {1'b0, b} + {32'd0, usex & xin};
        e.clo = lo[16];
        if (size) begin
            e.res = full[31:0];
            c     = full[32];
            n     = full[31];
            v     = (a[31] == b[31]) && (full[31] != a[31]);
            zb    = (full[31:0] == 32'd0);
        end else begin
            e.res = {a[31:16], lo[15:0]};
            c     = lo[16];
            n     = lo[15];
            v     = (a[15] == b[15]) && (lo[15] != a[15]);
            zb    = (lo[15:0] == 16'd0);
        end
        if (usex) zb = zb & zin;
        e.f = {c, n, zb, v, c};
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called mid-cycle; returns mid-cycle in the FIN cycle of this operation.
    task automatic op(input bit size, input bit usex, input bit xin, input bit zin,
                      input logic [31:0] a, input logic [31:0] b, input bit poke);
        exp_t        e;
        int          lat;
        logic [15:0] ea, eb;
        logic        ex;
        e     = model(size, usex, xin, zin, a, b);
        lat   = size ? 2 : 1;
        SIZE  = size;
        USE_X = usex;
        XIN   = xin;
        ZIN   = zin;
        A     = a;
        B     = b;
        START = 1'b1;
        @(posedge CLK);
        #1;
        START = 1'b0;
        A     = $urandom;
        B     = $urandom;
        XIN   = 1'($urandom_range(0, 1));
        ZIN   = 1'($urandom_range(0, 1));
        for (int k = 0; k <= lat; k++) begin
            if (k > 0) begin
                @(posedge CLK);
                #1;
                START = 1'b0;
            end
            if (k == 0) begin
                ea = a[15:0]; eb = b[15:0]; ex = usex & xin;
            end else if (k == 1 && size) begin
                ea = a[31:16]; eb = b[31:16]; ex = e.clo;
            end else begin
                ea = 16'd0; eb = 16'd0; ex = 1'b0;
            end
            chk("busy",  32'(BUSY),  32'(k < lat));
            chk("done",  32'(DONE),  32'(k == lat));
            chk("alu_a", 32'(ALU_A), 32'(ea));
            chk("alu_b", 32'(ALU_B), 32'(eb));
            chk("alu_x", 32'(ALU_X), 32'(ex));
            if (k == lat) begin
                prev_res = e.res;
                prev_f   = e.f;
            end
            chk("result", RESULT, prev_res);
            chk("flags_xnzvc", 32'({XF, NF, ZF, VF, CF}), 32'(prev_f));
            if (poke && k == 0) begin
                START = 1'b1;
                A     = 32'd1;
                B     = 32'd1;
            end
        end
    endtask

    task automatic idle_cycle();
        @(posedge CLK);
        #1;
        chk("idle_done", 32'(DONE), 32'd0);
        chk("idle_busy", 32'(BUSY), 32'd0);
        chk("idle_result", RESULT, prev_res);
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        prev_res = 32'd0;
        prev_f   = 5'd0;
        RESET = 1'b1;
        START = 1'b0;
        SIZE  = 1'b0;
        USE_X = 1'b0;
        XIN   = 1'b0;
        ZIN   = 1'b0;
        A     = 32'd0;
        B     = 32'd0;
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_result", RESULT, 32'd0);
        chk("rst_flags", 32'({XF, NF, ZF, VF, CF}), 32'd0);
        chk("rst_busy_done", 32'({BUSY, DONE}), 32'd0);
        chk("rst_alu", 32'({ALU_X, ALU_A, ALU_B[14:0]}), 32'd0);
        RESET = 1'b0;
        idle_cycle();

        // Directed cases
        op(1, 0, 0, 0, 32'h0000FFFF, 32'h00000001, 0); idle_cycle();
        op(1, 0, 0, 0, 32'h7FFFFFFF, 32'h00000001, 0); idle_cycle();
        op(1, 0, 0, 0, 32'hFFFFFFFF, 32'h00000001, 0); idle_cycle();
        op(0, 0, 0, 0, 32'h12347FFF, 32'hABCD0001, 0); idle_cycle();
        op(1, 1, 0, 0, 32'h00000000, 32'h00000000, 0); idle_cycle();
        op(1, 1, 0, 1, 32'h00000000, 32'h00000000, 0); idle_cycle();
        op(1, 1, 1, 0, 32'hFFFFFFFF, 32'h00000000, 0); idle_cycle();
        op(1, 1, 1, 1, 32'hFFFFFFFF, 32'h00000000, 0); idle_cycle();
        op(0, 1, 1, 1, 32'h5555FFFF, 32'h00000000, 0); idle_cycle();

        // START during LOW must be ignored
        op(1, 0, 0, 0, 32'h00120034, 32'h00560078, 1); idle_cycle();
        op(0, 0, 0, 0, 32'hCAFE1234, 32'h00001111, 1); idle_cycle();

        // Back-to-back: second START sampled in FIN
        op(1, 0, 0, 0, 32'h89ABCDEF, 32'h12345678, 0);
        op(0, 0, 0, 0, 32'h0000FFFF, 32'h00000001, 0);
        op(1, 1, 1, 1, 32'h80000000, 32'h80000000, 0);
        idle_cycle();

        // Reset asserted during HIGH aborts the operation
        SIZE  = 1'b1;
        USE_X = 1'b0;
        A     = 32'h1111FFFF;
        B     = 32'h22220001;
        START = 1'b1;
        @(posedge CLK);
        #1;
        START = 1'b0;
        @(posedge CLK);
        #1;
        chk("abort_high_busy", 32'(BUSY), 32'd1);
        chk("abort_high_alu_x", 32'(ALU_X), 32'd1);
        RESET = 1'b1;
        #1;
        prev_res = 32'd0;
        prev_f   = 5'd0;
        chk("abort_busy", 32'(BUSY), 32'd0);
        chk("abort_done", 32'(DONE), 32'd0);
        chk("abort_result", RESULT, 32'd0);
        chk("abort_flags", 32'({XF, NF, ZF, VF, CF}), 32'd0);
        chk("abort_alu_a", 32'(ALU_A), 32'd0);
        @(posedge CLK);
        #1;
        RESET = 1'b0;
        idle_cycle();
        idle_cycle();

        // Randomized operations, optionally chained back-to-back
        for (int i = 0; i < 40; i++) begin
            op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               $urandom, $urandom, 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 1) == 1) idle_cycle();
        end
        idle_cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_long_sequencer.md
Name: alu_long_sequencer

Overview:
- Drives the 16-bit Alu twice to perform 32-bit (long) adds, or once for word adds.
- Sits between operand fetch and the Alu. Supplies Alu a/b/x, consumes Alu o/c/z/v/n.
- Chains the low-half carry into the high-half extend input.
- Delivers a 32-bit result plus a merged 68k-style XNZVC flag set under a start/done handshake.

Parameters:
bits, 16, Alu datapath width; operand and result width is 2*bits

Ports:
CLK  input  1  system clock, rising edge
RESET  input  1  asynchronous, active-high reset
START  input  1  request pulse; sampled on CLK rising edge
SIZE  input  1  0 = word (one Alu pass), 1 = long (two passes); sampled with START
USE_X  input  1  1 = ADDX semantics (XIN used as carry-in, Z sticky); sampled with START
XIN  input  1  extend flag in; sampled with START
ZIN  input  1  current Z flag, for sticky Z; sampled with START
A  input  2*bits  operand A; sampled with START
B  input  2*bits  operand B; sampled with START
ALU_A  output  bits  to Alu a
ALU_B  output  bits  to Alu b
ALU_X  output  1  to Alu x (carry in)
ALU_O  input  bits  from Alu o
ALU_C  input  1  from Alu c
ALU_Z  input  1  from Alu z
ALU_V  input  1  from Alu v
ALU_N  input  1  from Alu n
RESULT  output  2*bits  registered result
XF, NF, ZF, VF, CF  output  1 each  registered flags
BUSY  output  1  high in LOW/HIGH states
DONE  output  1  one-cycle completion pulse

Behaviour:
- This block is fully synchronous to CLK except RESET. The Alu is combinational; each pass completes in one cycle.
- States:
  - IDLE
  - LOW: drive the low halves
  - HIGH: drive the high halves
  - FIN: DONE=1
- Reset (asynchronous, active-high):
  - state=IDLE.
  - RESULT=0, all flags=0, BUSY=0, DONE=0.
  - ALU_A=ALU_B=0, ALU_X=0.
- IDLE or FIN with START=1:
  - Latch SIZE, USE_X, XIN, ZIN, A, B.
  - Go to LOW.
- FIN with START=0: go to IDLE.
- START while BUSY=1 is ignored. Latched operands do not change.
- LOW state:
  - ALU_A=A[bits-1:0], ALU_B=B[bits-1:0].
  - ALU_X = USE_X ? XIN : 0.
  - At the edge: register the low result, c_lo=ALU_C, z_lo=ALU_Z, v_lo=ALU_V, n_lo=ALU_N.
  - Next state: HIGH if SIZE=1, otherwise FIN.
- HIGH state:
  - ALU_A=A[2*bits-1:bits], ALU_B=B[2*bits-1:bits].
  - ALU_X=c_lo (registered).
  - At the edge: register the high result and flags. Next state: FIN.
- ALU_A/ALU_B/ALU_X are 0 in IDLE and FIN.
- Latency, counted in edges after the edge that samples START:
  - Long: DONE is high after edge 2.
  - Word: DONE is high after edge 1.
  - DONE is high for exactly one cycle.
- RESULT and flags update only on the edge that enters FIN. They hold until the next completion or reset.
- Word result: RESULT = {A[2*bits-1:bits], low Alu result}. The upper half passes through unmodified.
- Flag rules:
  - Word: C=c_lo, V=v_lo, N=n_lo.
  - Long: C, V, N are taken from the high pass.
  - X=C in both sizes.
  - Base Z: word Z=z_lo; long Z = z_lo AND z_hi.
  - USE_X=1: Z = base Z AND latched ZIN (sticky; Z can only clear).
- Back-to-back: START sampled in FIN starts a new operation. DONE still pulses for the previous operation in that cycle.
- Reset mid-operation aborts the operation. No DONE is produced, and the outputs return to their reset values.
- Arithmetic is modulo 2^(2*bits). No saturation.

Test Plan:
- Long, A=0000FFFF, B=00000001, USE_X=0 -> in the HIGH cycle ALU_X=1. RESULT=00010000, C0 Z0 V0 N0 X0. DONE after edge 2, BUSY high for 2 cycles.
- Long, A=7FFFFFFF, B=00000001 -> RESULT=80000000, V1 N1 C0 Z0 X0.
- Long, A=FFFFFFFF, B=00000001 -> RESULT=00000000, C1 X1 Z1 V0 N0.
- Word, A=12347FFF, B=ABCD0001 -> RESULT=12348000, V1 N1 C0 Z0. DONE after edge 1, no HIGH cycle.
- ADDX sticky Z:
  - Long, USE_X=1, XIN=0, A=B=0, ZIN=0 -> RESULT=0, Z0.
  - Same operation with ZIN=1 -> Z1.
  - USE_X=1, XIN=1, A=FFFFFFFF, B=0 -> RESULT=0, C1 X1, Z equal to ZIN.
- Robustness:
  - Long op with a new START (A=1, B=1) pulsed during LOW -> ignored; the result is that of the first op.
  - RESET asserted during HIGH -> BUSY=0 immediately, no DONE, RESULT=0.
  - Back-to-back START held in FIN -> second op DONE 2 edges later.
